// File: rtl/fp_compare_pkg.sv
// Shared definitions for the pipelined IEEE-754 single-precision comparator:
// op encodings and small classification helpers used by every lane.
package fp_compare_pkg;

    typedef enum logic [1:0] {
        FCMP_LT    = 2'd0,
        FCMP_LE    = 2'd1,
        FCMP_EQ    = 2'd2,
        FCMP_UNORD = 2'd3
    } fcmp_op_e;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_snan(input logic [31:0] x);
        return fp_is_nan(x) && (x[22] == 1'b0);
    endfunction

    // Maps a non-NaN float onto an unsigned key whose integer order is the float order
    // (negatives inverted so larger magnitude sorts lower, positives lifted above them).
    function automatic logic [31:0] fp_order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp_compare_lane.sv
// Combinational single-lane IEEE-754 single-precision compare with invalid-operation flag.
module fp_compare_lane
    import fp_compare_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  fcmp_op_e    op,
    output logic        q,
    output logic        invalid
);

    logic any_nan_s;
    logic any_snan_s;
    logic both_zero_s;
    logic lt_s;
    logic eq_s;

    assign any_nan_s   = fp_is_nan(a) || fp_is_nan(b);
    assign any_snan_s  = fp_is_snan(a) || fp_is_snan(b);
    // +0 and -0 differ only in the sign bit and must compare equal.
    assign both_zero_s = ((a[30:0] | b[30:0]) == 31'd0);
    assign eq_s        = both_zero_s || (a == b);
    assign lt_s        = !both_zero_s && (fp_order_key(a) < fp_order_key(b));

    // Result and flag selection by compare mode; NaN operands force unordered behaviour.
    always_comb begin
        q       = 1'b0;
        invalid = 1'b0;
        case (op)
            FCMP_LT: begin
                q       = any_nan_s ? 1'b0 : lt_s;
                invalid = any_nan_s;
            end
            FCMP_LE: begin
                q       = any_nan_s ? 1'b0 : (lt_s || eq_s);
                invalid = any_nan_s;
            end
            FCMP_EQ: begin
                q       = any_nan_s ? 1'b0 : eq_s;
                invalid = any_snan_s;
            end
            FCMP_UNORD: begin
                q       = any_nan_s;
                invalid = any_snan_s;
            end
            default: begin
                q       = 1'b0;
                invalid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// LANES-wide IEEE-754 compare with a LATENCY-deep valid/ready pipeline; any output
// backpressure freezes the whole pipe.
module fp_compare_pipe
    import fp_compare_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [32*LANES-1:0]   a,
    input  logic [32*LANES-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      q,
    output logic [LANES-1:0]      invalid
);

    logic [LANES-1:0]   lane_q_s;
    logic [LANES-1:0]   lane_inv_s;
    logic               stall_s;
    logic [LATENCY-1:0] vld_r;
    logic [LANES-1:0]   q_r   [LATENCY];
    logic [LANES-1:0]   inv_r [LATENCY];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp_compare_lane u_lane (
            .a       (a[32*g +: 32]),
            .b       (b[32*g +: 32]),
            .op      (fcmp_op_e'(op)),
            .q       (lane_q_s[g]),
            .invalid (lane_inv_s[g])
        );
    end

    assign stall_s   = vld_r[LATENCY-1] && !out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = vld_r[LATENCY-1];
    assign q         = q_r[LATENCY-1];
    assign invalid   = inv_r[LATENCY-1];

    // Stage registers: load stage 1 from the lanes, shift the rest, hold everything on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                q_r[i]   <= '0;
                inv_r[i] <= '0;
            end
        end else if (!stall_s) begin
            vld_r[0] <= in_valid;
            q_r[0]   <= in_valid ? lane_q_s   : '0;
            inv_r[0] <= in_valid ? lane_inv_s : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
                q_r[i]   <= q_r[i-1];
                inv_r[i] <= inv_r[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed self-checking bench: single-lane LATENCY=2 instance plus a 4-lane LATENCY=5 instance.
module tb_fp_compare_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  q;
    logic [0:0]  invalid;

    logic         in_valid4 = 1'b0;
    logic         in_ready4;
    logic [127:0] a4 = 128'd0;
    logic [127:0] b4 = 128'd0;
    logic         out_valid4;
    logic [3:0]   q4;
    logic [3:0]   invalid4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_compare_pipe #(.LANES(1), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .invalid(invalid)
    );

    fp_compare_pipe #(.LANES(4), .LATENCY(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(1'b1), .q(q4), .invalid(invalid4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: accept on the next edge, result visible exactly one edge later.
    task automatic run1(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic eq, input logic ei);
        op = o; a = va; b = vb; in_valid = 1'b1;
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_q"}, {31'd0, q}, {31'd0, eq});
        check({tag, "_inv"}, {31'd0, invalid}, {31'd0, ei});
        step();
        check({tag, "_bubble"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] va_s [6];
    logic        eq_s [6];
    logic        ei_s [6];
    int          sent;
    int          got;
    logic        held_q;

    initial begin
        va_s[0] = 32'h3F80_0000; eq_s[0] = 1'b1; ei_s[0] = 1'b0;
        va_s[1] = 32'h4040_0000; eq_s[1] = 1'b0; ei_s[1] = 1'b0;
        va_s[2] = 32'h3F80_0000; eq_s[2] = 1'b1; ei_s[2] = 1'b0;
        va_s[3] = 32'h7FC0_0000; eq_s[3] = 1'b0; ei_s[3] = 1'b1;
        va_s[4] = 32'h3F80_0000; eq_s[4] = 1'b1; ei_s[4] = 1'b0;
        va_s[5] = 32'h4040_0000; eq_s[5] = 1'b0; ei_s[5] = 1'b0;

        // Reset state
        in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h4000_0000;
        repeat (2) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_q", {31'd0, q}, 32'd0);
        check("rst_inv", {31'd0, invalid}, 32'd0);
        check("rst_out_valid4", {31'd0, out_valid4}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic ordering, first acceptance right after release
        run1("lt_1_2", 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0);
        run1("eq_1_2", 2'd2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        run1("le_2_1", 2'd1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0);
        run1("lt_neg", 2'd0, 32'hC000_0000, 32'hBF80_0000, 1'b1, 1'b0);
        run1("lt_sub", 2'd0, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
        // Signed zero
        run1("eq_zero", 2'd2, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run1("lt_zero", 2'd0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run1("le_zero", 2'd1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        // NaN handling
        run1("eq_qnan", 2'd2, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0);
        run1("lt_qnan", 2'd0, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b1);
        run1("un_snan", 2'd3, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 1'b1);
        run1("un_qnan", 2'd3, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
        run1("eq_snan", 2'd2, 32'h3F80_0000, 32'hFF80_0001, 1'b0, 1'b1);

        // Backpressure: 6 back-to-back LT vs 2.0 with out_ready low on cycles 3..5
        op = 2'd0; b = 32'h4000_0000; sent = 0; got = 0; held_q = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid  = (sent < 6);
            a         = (sent < 6) ? va_s[sent] : 32'd0;
            out_ready = !(cyc >= 3 && cyc < 6);
            @(negedge clk);
            if (cyc >= 3 && cyc < 6) begin
                check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
                check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
                if (cyc == 3) held_q = q[0];
                else check("bp_stall_hold", {31'd0, q}, {31'd0, held_q});
            end
            if (out_valid && out_ready) begin
                check("bp_q", {31'd0, q}, {31'd0, eq_s[got]});
                check("bp_inv", {31'd0, invalid}, {31'd0, ei_s[got]});
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", got, 32'd6);
        repeat (3) begin
            check("bp_no_dup", {31'd0, out_valid}, 32'd0);
            step();
        end

        // Four lanes, LATENCY=5
        a4 = {32'h0000_0001, 32'h7F80_0000, 32'hBF80_0000, 32'h3F80_0000};
        b4 = {32'h0000_0002, 32'h7F80_0000, 32'hC000_0000, 32'h4000_0000};
        op = 2'd0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        repeat (3) step();
        check("l4_early", {31'd0, out_valid4}, 32'd0);
        step();
        check("l4_valid", {31'd0, out_valid4}, 32'd1);
        check("l4_q", {28'd0, q4}, 32'h9);
        check("l4_inv", {28'd0, invalid4}, 32'h0);
        step();
        check("l4_bubble", {31'd0, out_valid4}, 32'd0);

        // Reset with two results in flight
        op = 2'd0; a = 32'h3F80_0000; b = 32'h4000_0000; in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        check("rf_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rf_valid_now", {31'd0, out_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rf_after_rel", {31'd0, out_valid}, 32'd0);
        end
        run1("rf_new", 2'd1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 Parameter: LANES, default 1, number of independent 32-bit compare lanes (1..8).
REQ-002 Parameter: LATENCY, default 2, cycles from input acceptance to result valid (1..8).
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 op  input  2  compare mode: 0 LT, 1 LE, 2 EQ, 3 UNORD.
REQ-008 a  input  32*LANES  IEEE-754 single operands, lane i in bits [32i+31:32i].
REQ-009 b  input  32*LANES  second operands, same packing as a.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 q  output  LANES  per-lane compare result.
REQ-013 invalid  output  LANES  per-lane IEEE invalid-operation flag.

Function
REQ-014 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 Pipeline of LATENCY stages; each stage holds valid, q and invalid for all lanes; op and operands are consumed in stage 1.
REQ-016 stall = out_valid && !out_ready; stall freezes every stage; in_ready = !stall.
REQ-017 No stall: operand set accepted at edge t gives out_valid=1 with its result after edge t+LATENCY-1, i.e. visible for LATENCY cycles counted from the acceptance cycle inclusive; LATENCY=1 means registered after one edge.
REQ-018 Bubbles (in_valid=0) propagate as valid=0; results never reorder, duplicate or drop under any stall pattern.
REQ-019 Full throughput: one operand set per cycle when out_ready stays 1.
REQ-020 A stall held for N cycles holds q and invalid stable and adds exactly N cycles to all in-flight results.
REQ-021 Ordering: exact IEEE-754 ordering; +0 == -0; subnormals compared by value, no flush-to-zero; infinities ordered normally.
REQ-022 NaN: exponent all ones, mantissa nonzero; sNaN when mantissa bit 22 = 0, else qNaN.
REQ-023 LT/LE: q=0 if either operand is NaN; invalid=1 if either operand is any NaN.
REQ-024 EQ: q=0 if either operand is NaN; invalid=1 only if either operand is sNaN.
REQ-025 UNORD: q=1 iff either operand is NaN; invalid=1 only if either operand is sNaN.
REQ-026 Non-NaN operands always give invalid=0; the lanes are fully independent and all use the same op.

Reset
REQ-027 While reset=0: all stage valid bits, q and invalid are 0, so out_valid=0 and in_ready=1.
REQ-028 Reset asserted mid-operation discards all in-flight results; nothing emerges after release.
REQ-029 First acceptance is possible in the first cycle after reset release.

Structure
REQ-030 Shared package fp_compare_pkg holds the op encodings (FCMP_LT, FCMP_LE, FCMP_EQ, FCMP_UNORD) and the op type.
REQ-031 One combinational sub-module, fp_compare_lane, takes a, b and op and produces q and invalid; it is instantiated LANES times.
REQ-032 The pipeline, valid chain and stall logic live in fp_compare_pipe only.

Verification
REQ-033 LANES=1, LATENCY=2, out_ready=1: a=3F800000 (1.0), b=40000000 (2.0), op=LT at cycle 0 -> out_valid at cycle 2 with q=1, invalid=0; same operands with op=EQ -> q=0.
REQ-034 Signed zero: a=80000000, b=00000000; op=EQ -> q=1; op=LT -> q=0; op=LE -> q=1; invalid=0 in all three cases.
REQ-035 NaN: a=7FC00000 (qNaN), b=3F800000; op=EQ -> q=0, invalid=0; op=LT -> q=0, invalid=1; a=7F800001 (sNaN) with op=UNORD -> q=1, invalid=1.
REQ-036 Backpressure: stream of 6 back-to-back LT compares with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 6 results delivered in order, none lost or duplicated.
REQ-037 LANES=4, LATENCY=5: lanes {1.0<2.0, -1.0<-2.0, inf<inf, 0x00000001<0x00000002} with op=LT -> q=4'b1001 five cycles after acceptance.
REQ-038 Reset asserted with 2 results in flight -> out_valid=0 immediately and stays 0 after release until new input is accepted.
